// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_forward_unit
// Brief  : Decode register, destination history, operand forwarding selects,
//          load-use stall and memory-stage controls. Define ZERO_REG_EN to
//          make r0 a hard-wired zero register.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int FWD_STAGES = 3,
  parameter int IMM_W      = 16,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             ins_valid,
  input  logic             flush,
  output logic             stall,
  output logic [5:0]       op_dec,
  output logic [IMM_W-1:0] imm,
  output logic             imm_sel,
  output logic [SEL_W-1:0] mux_sel_A,
  output logic [SEL_W-1:0] mux_sel_B,
  output logic             mem_en_ex,
  output logic             mem_rw_ex,
  output logic             mem_mux_sel_dm,
  output logic [4:0]       wb_addr,
  output logic             wb_en
);

  localparam logic [5:0] c_OP_JMP = 6'b011000;
  localparam logic [5:0] c_OP_LD  = 6'b010100;
  localparam logic [5:0] c_OP_ST  = 6'b010101;

  // Fetch-side decode
  logic [5:0] w_op;
  logic       w_jmp, w_cj, w_ld, w_st, w_immc;
  assign w_op   = ins[31:26];
  assign w_jmp  = (w_op == c_OP_JMP);
  assign w_cj   = (w_op[5:2] == 4'b0111);
  assign w_ld   = (w_op == c_OP_LD);
  assign w_st   = (w_op == c_OP_ST);
  assign w_immc = (w_op[5:3] == 3'b001);

  // Decode register
  logic             r_d_valid, r_d_wr, r_d_uses, r_d_ld, r_d_st, r_d_immc;
  logic [5:0]       r_d_op;
  logic [4:0]       r_d_rd, r_d_ra, r_d_rb;
  logic [IMM_W-1:0] r_d_imm;

  // History stages 1..FWD_STAGES after decode
  logic [FWD_STAGES:1] r_s_valid, r_s_wr, r_s_ld, r_s_st;
  logic [4:0]          r_s_rd [1:FWD_STAGES];

  logic             w_stall_raw, w_ld_hit, w_push, w_live, w_dm, w_wb_en;
  logic [SEL_W-1:0] w_sel_a, w_sel_b;

  assign w_live = ~reset;
  assign w_push = ~w_stall_raw & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_d_valid <= 1'b0;
      r_d_wr    <= 1'b0;
      r_d_uses  <= 1'b0;
      r_d_ld    <= 1'b0;
      r_d_st    <= 1'b0;
      r_d_immc  <= 1'b0;
      r_d_op    <= '0;
      r_d_rd    <= '0;
      r_d_ra    <= '0;
      r_d_rb    <= '0;
      r_d_imm   <= '0;
    end else if (!w_stall_raw) begin
      r_d_valid <= ins_valid;
      r_d_wr    <= ins_valid & ~(w_jmp | w_cj | w_st);
      r_d_uses  <= ins_valid & ~(w_jmp | w_cj);
      r_d_ld    <= ins_valid & w_ld;
      r_d_st    <= ins_valid & w_st;
      r_d_immc  <= w_immc;
      r_d_op    <= w_op;
      r_d_rd    <= ins[25:21];
      r_d_ra    <= ins[20:16];
      r_d_rb    <= ins[15:11];
      r_d_imm   <= ins[IMM_W-1:0];
    end
  end

  // A stalled or squashed decode instruction leaves a bubble behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_valid <= '0;
      r_s_wr    <= '0;
      r_s_ld    <= '0;
      r_s_st    <= '0;
      for (int k = 1; k <= FWD_STAGES; k++) r_s_rd[k] <= '0;
    end else begin
      for (int k = FWD_STAGES; k >= 2; k--) begin
        r_s_valid[k] <= r_s_valid[k-1];
        r_s_wr[k]    <= r_s_wr[k-1];
        r_s_ld[k]    <= r_s_ld[k-1];
        r_s_st[k]    <= r_s_st[k-1];
        r_s_rd[k]    <= r_s_rd[k-1];
      end
      r_s_valid[1] <= w_push & r_d_valid;
      r_s_wr[1]    <= w_push & r_d_wr;
      r_s_ld[1]    <= w_push & r_d_ld;
      r_s_st[1]    <= w_push & r_d_st;
      r_s_rd[1]    <= w_push ? r_d_rd : 5'd0;
    end
  end

  // Scan oldest to youngest so the youngest matching stage overrides
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (r_s_valid[k] && r_s_wr[k] && (r_s_rd[k] == r_d_ra)) w_sel_a = SEL_W'(k);
      if (r_s_valid[k] && r_s_wr[k] && (r_s_rd[k] == r_d_rb)) w_sel_b = SEL_W'(k);
    end
    if (!r_d_uses) begin
      w_sel_a = '0;
      w_sel_b = '0;
    end
`ifdef ZERO_REG_EN
    if (r_d_ra == 5'd0) w_sel_a = '0;
    if (r_d_rb == 5'd0) w_sel_b = '0;
`endif
  end

  assign w_ld_hit = r_s_valid[1] & r_s_ld[1] & r_d_uses &
                    ((r_s_rd[1] == r_d_ra) | (r_s_rd[1] == r_d_rb));

`ifdef ZERO_REG_EN
  assign w_stall_raw = w_ld_hit & (r_s_rd[1] != 5'd0);
  assign w_wb_en     = r_s_valid[FWD_STAGES] & r_s_wr[FWD_STAGES] &
                       (r_s_rd[FWD_STAGES] != 5'd0);
`else
  assign w_stall_raw = w_ld_hit;
  assign w_wb_en     = r_s_valid[FWD_STAGES] & r_s_wr[FWD_STAGES];
`endif

  generate
    if (FWD_STAGES >= 2) begin : g_dm_stage2
      assign w_dm = r_s_valid[2] & r_s_ld[2];
    end else begin : g_dm_tie
      assign w_dm = 1'b0;
    end
  endgenerate

  // Outputs are forced low while reset is asserted, before the registers clear
  assign stall          = w_stall_raw & w_live;
  assign op_dec         = r_d_op & {6{r_d_valid & w_live}};
  assign imm            = r_d_imm & {IMM_W{r_d_valid & w_live}};
  assign imm_sel        = r_d_immc & r_d_valid & w_live;
  assign mux_sel_A      = w_sel_a & {SEL_W{w_live}};
  assign mux_sel_B      = w_sel_b & {SEL_W{w_live}};
  assign mem_en_ex      = r_s_valid[1] & (r_s_ld[1] | r_s_st[1]) & w_live;
  assign mem_rw_ex      = r_s_valid[1] & r_s_st[1] & w_live;
  assign mem_mux_sel_dm = w_dm & w_live;
  assign wb_addr        = r_s_rd[FWD_STAGES] & {5{w_live}};
  assign wb_en          = w_wb_en & w_live;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, r_s_ld, r_s_st, ins};

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_forward_unit
// Brief  : Directed and randomized bench for hazard_forward_unit with a
//          queue-based reference model of the decode/history pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_forward_unit;

  localparam int N  = 3;
  localparam int IW = 16;
  localparam int SW = $clog2(N + 1);

  localparam logic [5:0] OP_ALU  = 6'b000001;
  localparam logic [5:0] OP_ALU2 = 6'b000011;
  localparam logic [5:0] OP_LD   = 6'b010100;
  localparam logic [5:0] OP_ST   = 6'b010101;
  localparam logic [5:0] OP_JMP  = 6'b011000;

`ifdef ZERO_REG_EN
  localparam int ZR = 1;
`else
  localparam int ZR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   ins = '0;
  logic          ins_valid = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [5:0]    op_dec;
  logic [IW-1:0] imm;
  logic          imm_sel;
  logic [SW-1:0] mux_sel_A, mux_sel_B;
  logic          mem_en_ex, mem_rw_ex, mem_mux_sel_dm;
  logic [4:0]    wb_addr;
  logic          wb_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.FWD_STAGES(N), .IMM_W(IW)) dut (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .flush(flush),
    .stall(stall), .op_dec(op_dec), .imm(imm), .imm_sel(imm_sel),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
    .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .wb_addr(wb_addr), .wb_en(wb_en)
  );

  // Reference model: an instruction is a valid bit plus its raw word
  typedef struct packed {
    logic        v;
    logic [31:0] w;
  } instr_t;

  instr_t m_d;
  instr_t m_hist[$];   // m_hist[0] is the stage right after decode

  function automatic logic [5:0] f_op(input instr_t e); return e.w[31:26]; endfunction
  function automatic logic [4:0] f_rd(input instr_t e); return e.w[25:21]; endfunction
  function automatic logic [4:0] f_ra(input instr_t e); return e.w[20:16]; endfunction
  function automatic logic [4:0] f_rb(input instr_t e); return e.w[15:11]; endfunction

  function automatic logic is_ctl(input instr_t e);
    logic [5:0] op;
    op = f_op(e);
    return (op == OP_JMP) || (op[5:2] == 4'b0111);
  endfunction
  function automatic logic is_ld(input instr_t e); return e.v && (f_op(e) == OP_LD); endfunction
  function automatic logic is_st(input instr_t e); return e.v && (f_op(e) == OP_ST); endfunction
  function automatic logic uses(input instr_t e); return e.v && !is_ctl(e); endfunction
  function automatic logic writes(input instr_t e);
    return e.v && !is_ctl(e) && (f_op(e) != OP_ST);
  endfunction

  function automatic int exp_sel(input logic [4:0] addr);
    if (!uses(m_d)) return 0;
    if (ZR == 1 && addr == 5'd0) return 0;
    for (int i = 0; i < N; i++)
      if (writes(m_hist[i]) && f_rd(m_hist[i]) == addr) return i + 1;
    return 0;
  endfunction

  function automatic logic exp_stall();
    instr_t s;
    s = m_hist[0];
    if (ZR == 1 && f_rd(s) == 5'd0) return 1'b0;
    return is_ld(s) && uses(m_d) && (f_rd(s) == f_ra(m_d) || f_rd(s) == f_rb(m_d));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [5:0] op;
    instr_t     wbs;
    op  = f_op(m_d);
    wbs = m_hist[N-1];
    if (reset) begin
      chk("rst_stall", 32'(stall), 0);
      chk("rst_op_dec", 32'(op_dec), 0);
      chk("rst_sel_A", 32'(mux_sel_A), 0);
      chk("rst_sel_B", 32'(mux_sel_B), 0);
      chk("rst_mem_en", 32'(mem_en_ex), 0);
      chk("rst_wb_en", 32'(wb_en), 0);
    end else begin
      chk("m_stall", 32'(stall), 32'(exp_stall()));
      chk("m_op_dec", 32'(op_dec), m_d.v ? 32'(op) : 0);
      chk("m_imm", 32'(imm), m_d.v ? 32'(m_d.w[IW-1:0]) : 0);
      chk("m_imm_sel", 32'(imm_sel), 32'(m_d.v && op[5:3] == 3'b001));
      chk("m_sel_A", 32'(mux_sel_A), 32'(exp_sel(f_ra(m_d))));
      chk("m_sel_B", 32'(mux_sel_B), 32'(exp_sel(f_rb(m_d))));
      chk("m_mem_en", 32'(mem_en_ex), 32'(is_ld(m_hist[0]) || is_st(m_hist[0])));
      chk("m_mem_rw", 32'(mem_rw_ex), 32'(is_st(m_hist[0])));
      chk("m_mem_dm", 32'(mem_mux_sel_dm), 32'(N >= 2 && is_ld(m_hist[1])));
      chk("m_wb_addr", 32'(wb_addr), 32'(f_rd(wbs)));
      chk("m_wb_en", 32'(wb_en), 32'(writes(wbs) && !(ZR == 1 && f_rd(wbs) == 5'd0)));
    end
  endtask

  task automatic model_step();
    logic   st;
    instr_t e;
    st = exp_stall();
    if (reset) begin
      m_d = '0;
      for (int i = 0; i < N; i++) m_hist[i] = '0;
    end else begin
      e = (st || flush) ? instr_t'('0) : m_d;
      m_hist.push_front(e);
      void'(m_hist.pop_back());
      if (flush)    m_d = '0;
      else if (!st) m_d = '{v: ins_valid, w: ins};
    end
  endtask

  // One clock: drive, check the current state, advance model and DUT
  task automatic cyc(input logic [31:0] i, input logic v, input logic f, input logic r);
    ins = i; ins_valid = v; flush = f; reset = r;
    #1;
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 11'h0a5};
  endfunction

  initial begin
    logic [31:0] w;
    logic [5:0]  op;
    int          r;

    m_d = '0;
    for (int i = 0; i < N; i++) m_hist.push_back('0);

    // Reset and the cycle after it
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("post_rst_stall", 32'(stall), 0);
    chk("post_rst_op_dec", 32'(op_dec), 0);
    chk("post_rst_wb_en", 32'(wb_en), 0);

    // Back-to-back dependency
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd4, 5'd3, 5'd5), 1'b1, 1'b0, 1'b0);
    chk("b2b_sel_A", 32'(mux_sel_A), 1);
    chk("b2b_sel_B", 32'(mux_sel_B), 0);
    chk("b2b_stall", 32'(stall), 0);

    // Forward from the oldest stage, then out of the window
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd10, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd13, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd9, 5'd20, 5'd3), 1'b1, 1'b0, 1'b0);
    chk("win_sel_B", 32'(mux_sel_B), 3);
    chk("win_sel_A", 32'(mux_sel_A), 0);
    chk("win_wb_addr", 32'(wb_addr), 3);
    chk("win_wb_en", 32'(wb_en), 1);
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd10, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd13, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd14, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd9, 5'd20, 5'd3), 1'b1, 1'b0, 1'b0);
    chk("out_sel_B", 32'(mux_sel_B), 0);

    // Load-use: one stall cycle, then forward from stage 2
    cyc(mk(OP_LD, 5'd7, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU2, 5'd8, 5'd7, 5'd7), 1'b1, 1'b0, 1'b0);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_mem_en", 32'(mem_en_ex), 1);
    chk("lu_mem_rw", 32'(mem_rw_ex), 0);
    cyc(mk(OP_ALU2, 5'd8, 5'd7, 5'd7), 1'b1, 1'b0, 1'b0);
    chk("lu_stall_drop", 32'(stall), 0);
    chk("lu_sel_A", 32'(mux_sel_A), 2);
    chk("lu_sel_B", 32'(mux_sel_B), 2);
    chk("lu_dm", 32'(mem_mux_sel_dm), 1);
    chk("lu_held_op", 32'(op_dec), 32'(OP_ALU2));

    // Store does not write its RD field
    cyc(mk(OP_ST, 5'd6, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd9, 5'd6, 5'd6), 1'b1, 1'b0, 1'b0);
    chk("st_sel_A", 32'(mux_sel_A), 0);
    chk("st_mem_en", 32'(mem_en_ex), 1);
    chk("st_mem_rw", 32'(mem_rw_ex), 1);

    // Flush together with stall
    cyc(mk(OP_LD, 5'd7, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU2, 5'd8, 5'd7, 5'd1), 1'b1, 1'b0, 1'b0);
    chk("fl_pre_stall", 32'(stall), 1);
    cyc(mk(OP_ALU2, 5'd8, 5'd7, 5'd1), 1'b1, 1'b1, 1'b0);
    chk("fl_stall", 32'(stall), 0);
    chk("fl_op_dec", 32'(op_dec), 0);
    chk("fl_mem_en", 32'(mem_en_ex), 0);

    // Reset with writers in flight
    cyc(mk(OP_ALU, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd4, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd6, 5'd3, 5'd4), 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("mr_wb_en", 32'(wb_en), 0);
    chk("mr_sel_A", 32'(mux_sel_A), 0);
    chk("mr_op_dec", 32'(op_dec), 0);
    cyc(mk(OP_ALU, 5'd6, 5'd3, 5'd4), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd7, 5'd5, 5'd4), 1'b1, 1'b0, 1'b0);
    chk("mr_rd_sel_A", 32'(mux_sel_A), 0);
    chk("mr_rd_sel_B", 32'(mux_sel_B), 0);

    // Register r0
    cyc(mk(OP_ALU, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
    chk("r0_sel_A", 32'(mux_sel_A), (ZR == 1) ? 0 : 1);
    chk("r0_sel_B", 32'(mux_sel_B), (ZR == 1) ? 0 : 1);
    cyc(mk(OP_ALU, 5'd10, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0);
    cyc(mk(OP_ALU, 5'd10, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0);
    chk("r0_wb_addr", 32'(wb_addr), 0);
    chk("r0_wb_en", 32'(wb_en), (ZR == 1) ? 0 : 1);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 5))
        0:       op = 6'($urandom);
        1:       op = OP_LD;
        2:       op = OP_ST;
        3:       op = OP_JMP;
        4:       op = {4'b0111, 2'($urandom)};
        default: op = {3'b001, 3'($urandom)};
      endcase
      w = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 11'($urandom)};
      cyc(w, ($urandom_range(0, 9) != 0), (r >= 2 && r < 8), (r < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the 16-bit-data, 32-bit-instruction pipelined core.
- Sits between fetch and the execute-stage operand muxes.
- Decodes each instruction, tracks destination registers over a configurable forwarding window, and drives the A/B forwarding selects, a load-use stall, and aligned memory-stage controls.
- Adds per-stage valid bits, real stall/bubble insertion and external flush.

Parameters:
- FWD_STAGES, 3, forwarding window depth in stages after decode (1..4).
- IMM_W, 16, width of registered immediate (taken from ins[IMM_W-1:0], IMM_W <= 16).
- SEL_W, $clog2(FWD_STAGES+1), derived width of forwarding selects; do not override.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ins  input  32  fetched instruction: op=[31:26], RD=[25:21], RA=[20:16], RB=[15:11].
- ins_valid  input  1  ins holds a real instruction this cycle.
- flush  input  1  branch taken; squash decode-stage instruction.
- stall  output  1  load-use stall; upstream holds ins while high.
- op_dec  output  6  registered opcode of decode-stage instruction.
- imm  output  IMM_W  registered immediate.
- imm_sel  output  1  decode instruction is immediate class (op[5:3]==3'b001).
- mux_sel_A, mux_sel_B  output  SEL_W  0 = register file, k = forward from stage k.
- mem_en_ex  output  1  execute-stage instruction is LD or ST.
- mem_rw_ex  output  1  execute-stage instruction is ST.
- mem_mux_sel_dm  output  1  memory-stage instruction is LD (select memory data).
- wb_addr  output  5  destination of oldest tracked stage (stage FWD_STAGES).
- wb_en  output  1  that stage is valid and writes.

Behaviour:
- Opcode classes: JMP=6'b011000; COND_J=op[5:2]==4'b0111; LD=6'b010100; ST=6'b010101; IMM=op[5:3]==3'b001.
- Writes-RD = valid & ~(JMP|COND_J|ST). Uses-RA/RB = valid & ~(JMP|COND_J).
- Decode register (D) fields: valid, op, RD, RA, RB, imm, class bits.
  - reset or flush: D cleared.
  - stall: D held.
  - else: D loads ins, with valid = ins_valid.
- History S[1..FWD_STAGES] fields: valid, rd, wr, ld, st. Each clk: S[k] <= S[k-1].
  - S[1] <= D when ~stall & ~flush; otherwise S[1] <= bubble (all zero).
  - reset clears all stages.
- Forward select (combinational from registers): mux_sel_A = smallest k with S[k].valid & S[k].wr & S[k].rd==D.RA & D.uses; else 0. mux_sel_B identical using RB. The youngest stage wins.
- Stall (combinational from registers) = S[1].valid & S[1].ld & D.uses & (S[1].rd==D.RA | S[1].rd==D.RB).
  - Lasts exactly one cycle: the next cycle S[1] is a bubble and the load is in S[2], so it forwards with sel=2.
- flush and stall in the same cycle: flush wins, D cleared, stall drops next cycle.
- Outputs (combinational from registers):
  - op_dec/imm/imm_sel come from D and read 0 when D invalid.
  - mem_en_ex = S[1].valid & (ld|st); mem_rw_ex = S[1].st.
  - mem_mux_sel_dm = S[2].valid & S[2].ld; tie to 0 if FWD_STAGES==1.
  - wb_addr/wb_en from S[FWD_STAGES].
- Every output is 0 during reset and in the cycle after it.
- Reset asserted mid-operation discards all in-flight state within one clk; no partial forwarding.
- Invalid stages never match, including RD==0 bubbles.

Optional Feature:
- ZERO_REG_EN defined: r0 is hard-wired zero.
  - Any operand address 0 forces its select to 0.
  - Stall is never raised on a match where S[1].rd==0.
  - wb_en=0 when rd==0.
- Undefined: r0 is an ordinary register and is forwarded/stalled like any other.

Test Plan:
- ADD r3<-r1,r2 then ADD r4<-r3,r5 back-to-back -> cycle the second is in D: mux_sel_A=1, mux_sel_B=0, stall=0.
- Writer r3, two unrelated instructions, reader of r3 in RB -> mux_sel_B=3 (FWD_STAGES=3). One more filler -> mux_sel_B=0.
- LD r7 (op 010100) then ADD r8<-r7,r7 -> stall=1 for exactly one cycle with D held. Next cycle mux_sel_A=mux_sel_B=2, mem_mux_sel_dm=1 that cycle.
- ST followed by reader of the ST's RD field -> no forward (sel=0). mem_en_ex=1 and mem_rw_ex=1 the cycle the ST is in S[1].
- flush asserted together with stall -> D cleared, next cycle stall=0, op_dec=0, S[1] bubble.
- reset pulsed while three writers are in flight -> all outputs 0 next cycle. A reader of their registers afterwards sees sel=0. With ZERO_REG_EN, a writer and reader of r0 give sel=0 and wb_en=0.
